// File: rtl/io_port_bank_pkg.sv
// io_port_bank shared constants: register offsets, STATUS bits, FSM encodings.
// Also holds the divisor-to-bit-length helper used by both TX and RX.
package io_port_bank_pkg;

  localparam logic [7:0] A_LED    = 8'h00;
  localparam logic [7:0] A_TXDATA = 8'h04;
  localparam logic [7:0] A_STATUS = 8'h08;
  localparam logic [7:0] A_RXDATA = 8'h0C;
  localparam logic [7:0] A_CYC_LO = 8'h10;
  localparam logic [7:0] A_CYC_HI = 8'h14;
  localparam logic [7:0] A_BAUD   = 8'h18;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_VALID = 2;
  localparam int ST_RX_OVR   = 3;
  localparam int ST_RX_FERR  = 4;

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  // A divisor of zero still yields one clock per bit.
  function automatic logic [15:0] bit_clks(input logic [15:0] div);
    return (div == 16'd0) ? 16'd1 : div;
  endfunction

endpackage

// File: rtl/io_uart_tx.sv
// UART transmitter: byte FIFO feeding an 8N1 shifter.
// The divisor is sampled at every bit boundary.
module io_uart_tx
  import io_port_bank_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        i_push,
  input  logic [7:0]  i_data,
  input  logic [15:0] i_div,
  output logic        o_full,
  output logic        o_empty,
  output logic        o_tx
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [1:0]    r_state;
  logic [15:0]   r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_tx;

  logic w_fifo_empty;
  logic w_full;
  logic w_bit_end;
  logic w_pop;
  logic w_push;

  assign w_fifo_empty = (r_count == '0);
  assign w_full       = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_bit_end    = (r_cnt == 16'd0);
  assign w_pop  = !w_fifo_empty &&
                  ((r_state == TX_IDLE) ||
                   (r_state == TX_STOP && w_bit_end));
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push = i_push && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (!w_push && w_pop) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_state <= TX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      if (!w_bit_end) r_cnt <= r_cnt - 16'd1;
      case (r_state)
        TX_START: if (w_bit_end) begin
          r_state <= TX_DATA;
          r_tx    <= r_shift[0];
          r_bit   <= '0;
          r_cnt   <= bit_clks(i_div) - 16'd1;
        end
        TX_DATA: if (w_bit_end) begin
          r_cnt <= bit_clks(i_div) - 16'd1;
          if (r_bit == 3'd7) begin
            r_state <= TX_STOP;
            r_tx    <= 1'b1;
          end else begin
            r_bit   <= r_bit + 3'd1;
            r_shift <= r_shift >> 1;
            r_tx    <= r_shift[1];
          end
        end
        default: if (w_pop) begin
          r_state <= TX_START;
          r_shift <= r_mem[r_rptr];
          r_tx    <= 1'b0;
          r_cnt   <= bit_clks(i_div) - 16'd1;
        end else if (r_state == TX_STOP && w_bit_end) begin
          r_state <= TX_IDLE;
        end
      endcase
    end
  end

  assign o_full  = w_full;
  assign o_empty = w_fifo_empty && (r_state == TX_IDLE);
  assign o_tx    = r_tx;

endmodule

// File: rtl/io_port_bank.sv
// Memory-mapped LED / UART / cycle-counter IO bank.
// Optional UART receive path is built only with IO_UART_RX_EN defined.
module io_port_bank
  import io_port_bank_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int DEFAULT_DIV = 217
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic [7:0]  io_addr,
  input  logic        io_en,
  input  logic        io_we,
  input  logic [31:0] io_data_write,
  output logic [31:0] io_data_read,
  output logic [7:0]  leds,
  output logic        uart_tx,
  input  logic        uart_rx
);

  logic [7:0]  r_leds;
  logic [15:0] r_div;
  logic [63:0] r_cycle;

  logic w_wr;
  logic w_rd;
  logic w_tx_full;
  logic w_tx_empty;
  logic w_rx_valid;
  logic w_rx_ovr;
  logic w_rx_ferr;
  logic [7:0]  w_rx_data;
  logic [31:0] w_status;
  logic w_unused;

  assign w_wr = io_en && io_we;
  assign w_rd = io_en && !io_we;

  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_leds  <= '0;
      r_div   <= 16'(DEFAULT_DIV);
      r_cycle <= '0;
    end else begin
      r_cycle <= r_cycle + 64'd1;
      if (w_wr && io_addr == A_LED)  r_leds <= io_data_write[7:0];
      if (w_wr && io_addr == A_BAUD) r_div  <= io_data_write[15:0];
    end
  end

  io_uart_tx #(.FIFO_DEPTH(FIFO_DEPTH)) u_tx (
    .clk     (clk),
    .resetb  (resetb),
    .i_push  (w_wr && io_addr == A_TXDATA),
    .i_data  (io_data_write[7:0]),
    .i_div   (r_div),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_tx    (uart_tx)
  );

`ifdef IO_UART_RX_EN
  logic        r_rx_s1;
  logic        r_rx_s2;
  logic        r_rx_s3;
  logic [1:0]  r_rx_state;
  logic [15:0] r_rx_cnt;
  logic [2:0]  r_rx_bit;
  logic [7:0]  r_rx_sh;
  logic [7:0]  r_rx_data;
  logic        r_rx_valid;
  logic        r_rx_ovr;
  logic        r_rx_ferr;
  logic        w_rx_pop;
  logic        w_rx_w1c;

  assign w_rx_pop = w_rd && io_addr == A_RXDATA;
  assign w_rx_w1c = w_wr && io_addr == A_STATUS &&
                    io_data_write[ST_RX_OVR];

  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_s3    <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_sh    <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_rx_ovr   <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      r_rx_s1 <= uart_rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
      if (r_rx_cnt != 16'd0) r_rx_cnt <= r_rx_cnt - 16'd1;
      if (w_rx_pop) r_rx_valid <= 1'b0;
      if (w_rx_w1c) r_rx_ovr   <= 1'b0;
      case (r_rx_state)
        RX_START: if (r_rx_cnt == 16'd0) begin
          r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
          r_rx_bit   <= '0;
          r_rx_cnt   <= bit_clks(r_div) - 16'd1;
        end
        RX_DATA: if (r_rx_cnt == 16'd0) begin
          r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
          r_rx_cnt <= bit_clks(r_div) - 16'd1;
          r_rx_bit <= r_rx_bit + 3'd1;
          if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
        end
        RX_STOP: if (r_rx_cnt == 16'd0) begin
          r_rx_state <= RX_IDLE;
          if (!r_rx_s2) begin
            r_rx_ferr <= 1'b1;
          end else if (r_rx_valid && !w_rx_pop) begin
            r_rx_ovr <= 1'b1;
          end else begin
            r_rx_data  <= r_rx_sh;
            r_rx_valid <= 1'b1;
          end
        end
        default: if (r_rx_s3 && !r_rx_s2) begin
          r_rx_state <= RX_START;
          r_rx_cnt   <= bit_clks(r_div) >> 1;
        end
      endcase
    end
  end

  assign w_rx_valid = r_rx_valid;
  assign w_rx_ovr   = r_rx_ovr;
  assign w_rx_ferr  = r_rx_ferr;
  assign w_rx_data  = r_rx_data;
  assign w_unused   = ^io_data_write[31:16];
`else
  assign w_rx_valid = 1'b0;
  assign w_rx_ovr   = 1'b0;
  assign w_rx_ferr  = 1'b0;
  assign w_rx_data  = '0;
  assign w_unused   = ^{io_data_write[31:16], uart_rx};
`endif

  always_comb begin
    w_status              = '0;
    w_status[ST_TX_FULL]  = w_tx_full;
    w_status[ST_TX_EMPTY] = w_tx_empty;
    w_status[ST_RX_VALID] = w_rx_valid;
    w_status[ST_RX_OVR]   = w_rx_ovr;
    w_status[ST_RX_FERR]  = w_rx_ferr;
  end

  always_comb begin
    io_data_read = '0;
    if (io_en) begin
      case (io_addr)
        A_LED:    io_data_read = {24'd0, r_leds};
        A_STATUS: io_data_read = w_status;
        A_RXDATA: io_data_read = {24'd0, w_rx_data};
        A_CYC_LO: io_data_read = r_cycle[31:0];
        A_CYC_HI: io_data_read = r_cycle[63:32];
        A_BAUD:   io_data_read = {16'd0, r_div};
        default:  io_data_read = '0;
      endcase
    end
  end

  assign leds = r_leds;

endmodule
